// File: rtl/draw_point_slave_if.sv
// Point-plot strobes, clear command, pixel-memory write port and status for draw_point_slave.
// The slave modport is the block's view; the master modport is the surrounding system's view.
interface draw_point_slave_if #(
    parameter int ADDR_W = 17
);
    logic              ul1Update;
    logic [8:0]        ul9PosX;
    logic [8:0]        ul9PosY;
    logic [11:0]       ul12Rgb12Data;
    logic              ul1Clear;
    logic [11:0]       ul12ClearRgb;
    logic [ADDR_W-1:0] ulMemAddress;
    logic              ul1MemWrite;
    logic [11:0]       ul12MemWriteData;
    logic              ul1MemWaitRequest;
    logic              ul1Busy;
    logic              ul1Overflow;
    logic [15:0]       ul16DropCount;

    modport slave (
        input  ul1Update, ul9PosX, ul9PosY, ul12Rgb12Data, ul1Clear, ul12ClearRgb,
        input  ul1MemWaitRequest,
        output ulMemAddress, ul1MemWrite, ul12MemWriteData,
        output ul1Busy, ul1Overflow, ul16DropCount
    );

    modport master (
        output ul1Update, ul9PosX, ul9PosY, ul12Rgb12Data, ul1Clear, ul12ClearRgb,
        output ul1MemWaitRequest,
        input  ulMemAddress, ul1MemWrite, ul12MemWriteData,
        input  ul1Busy, ul1Overflow, ul16DropCount
    );
endinterface

// File: rtl/draw_point_slave.sv
// DrawPoint receiver: buffers plotted points in a FIFO and writes them to pixel memory,
// performs whole-frame fills on command and keeps drop statistics.
//
// state | meaning
// IDLE  | no write outstanding; pops the next point or starts a pending fill
// WRITE | a point write is on the memory port, waiting for acceptance
// CLEAR | sweeping the whole frame with the latched fill colour
module draw_point_slave #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input logic              ul1Clock,
    input logic              ul1Reset_n,
    draw_point_slave_if.slave dp
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 30;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      fifo_count;
    logic                clear_pending;
    logic [11:0]         fill_rgb;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_write;
    logic [11:0]         mem_data;
    logic                overflow;
    logic [15:0]         drop_count;

    logic [ENTRY_W-1:0]  head;
    logic [8:0]          head_x;
    logic [8:0]          head_y;
    logic [11:0]         head_rgb;
    logic [ADDR_W-1:0]   head_addr;
    logic                in_range;
    logic                fifo_full;
    logic                fifo_empty;
    logic                clear_req;
    logic                accept;
    logic                slot_free;
    logic                start_clear;
    logic                pop;
    logic                capture;
    logic                push;
    logic                drop;
    logic [11:0]         fill_next;

    assign head      = fifo_mem[rd_ptr];
    assign head_x    = head[29:21];
    assign head_y    = head[20:12];
    assign head_rgb  = head[11:0];
    assign head_addr = ADDR_W'(head_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head_x);

    assign in_range   = (32'(dp.ul9PosX) < 32'(FB_WIDTH)) && (32'(dp.ul9PosY) < 32'(FB_HEIGHT));
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);

    // The memory port is free to take new work when idle or when the current write is accepted.
    assign clear_req   = clear_pending | dp.ul1Clear;
    assign accept      = mem_write & ~dp.ul1MemWaitRequest;
    assign slot_free   = (state == IDLE) | ((state == WRITE) & accept);
    assign start_clear = slot_free & clear_req;
    assign pop         = slot_free & ~clear_req & ~fifo_empty;

    // Fullness is judged on the count before this edge, so a simultaneous pop never makes room.
    // A point arriving on the edge that starts a fill is discarded with the flushed FIFO.
    assign capture   = dp.ul1Update & (state != CLEAR) & ~start_clear;
    assign push      = capture & in_range & ~fifo_full;
    assign drop      = capture & ~(in_range & ~fifo_full);
    assign fill_next = clear_pending ? fill_rgb : dp.ul12ClearRgb;

    always_ff @(posedge ul1Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dp.ul9PosX, dp.ul9PosY, dp.ul12Rgb12Data};
        end
    end

    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            clear_pending <= 1'b0;
            fill_rgb      <= '0;
            mem_addr      <= '0;
            mem_write     <= 1'b0;
            mem_data      <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
        end else begin
            if (start_clear) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      fifo_count <= fifo_count + (PTR_W + 1)'(1);
                else if (pop && !push) fifo_count <= fifo_count - (PTR_W + 1)'(1);
            end

            if (start_clear) begin
                drop_count <= '0;
                overflow   <= 1'b0;
            end else if (drop) begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                if (in_range) overflow <= 1'b1;
            end

            if (start_clear) begin
                state         <= CLEAR;
                mem_addr      <= '0;
                mem_data      <= fill_next;
                fill_rgb      <= fill_next;
                mem_write     <= 1'b1;
                clear_pending <= 1'b0;
            end else if (pop) begin
                state     <= WRITE;
                mem_addr  <= head_addr;
                mem_data  <= head_rgb;
                mem_write <= 1'b1;
            end else begin
                case (state)
                    WRITE: begin
                        if (accept) begin
                            mem_write <= 1'b0;
                            state     <= IDLE;
                        end else if (dp.ul1Clear && !clear_pending) begin
                            // Stalled write must finish first; remember the fill and its colour.
                            clear_pending <= 1'b1;
                            fill_rgb      <= dp.ul12ClearRgb;
                        end
                    end
                    CLEAR: begin
                        if (accept) begin
                            if (mem_addr == LAST_ADDR) begin
                                mem_write <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                mem_addr <= mem_addr + ADDR_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dp.ulMemAddress     = mem_addr;
    assign dp.ul1MemWrite      = mem_write;
    assign dp.ul12MemWriteData = mem_data;
    assign dp.ul1Busy          = (state != IDLE) | ~fifo_empty;
    assign dp.ul1Overflow      = overflow;
    assign dp.ul16DropCount    = drop_count;
endmodule

// File: tb/tb_draw_point_slave.sv
// Self-checking bench for draw_point_slave: scenario tasks compare observed memory writes
// and status against a queue-based model of the point-plot rules.
module tb_draw_point_slave;
    localparam int W      = 320;
    localparam int H      = 240;
    localparam int AW     = 17;
    localparam int NPIX   = W * H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    draw_point_slave_if #(.ADDR_W(AW)) dp ();

    draw_point_slave #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW), .FIFO_DEPTH(8)
    ) dut (
        .ul1Clock  (clk),
        .ul1Reset_n(rst_n),
        .dp        (dp)
    );

    int  checks = 0;
    int  errors = 0;
    int  model_drops = 0;
    bit  model_ovf = 1'b0;
    bit  rand_wait = 1'b0;
    wr_t obs_q[$];
    wr_t exp_q[$];

    // Every accepted write, sampled mid-cycle when the port and WaitRequest are settled.
    always @(negedge clk) begin
        if (rst_n && dp.ul1MemWrite && !dp.ul1MemWaitRequest)
            obs_q.push_back('{addr: dp.ulMemAddress, data: dp.ul12MemWriteData});
    end

    function automatic wr_t expect_wr(int x, int y, logic [11:0] rgb);
        wr_t w;
        w.addr = AW'(y * W + x);
        w.data = rgb;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_wait) dp.ul1MemWaitRequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send_point(int x, int y, logic [11:0] rgb);
        dp.ul1Update     = 1'b1;
        dp.ul9PosX       = 9'(x);
        dp.ul9PosY       = 9'(y);
        dp.ul12Rgb12Data = rgb;
        tick();
        dp.ul1Update = 1'b0;
    endtask

    task automatic wait_idle(int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            @(negedge clk);
            if (!dp.ul1Busy && !dp.ul1MemWrite) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic compare_queues(string name);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %h want addr %0d data %h",
                         name, i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic check_stats(string name);
        checks++;
        if (dp.ul16DropCount !== 16'(model_drops)) begin
            errors++;
            $display("FAIL %s dropcount: got %0d want %0d", name, dp.ul16DropCount, model_drops);
        end
        checks++;
        if (dp.ul1Overflow !== model_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b want %b", name, dp.ul1Overflow, model_ovf);
        end
    endtask

    task automatic test_reset();
        dp.ul1Update = 0; dp.ul9PosX = 0; dp.ul9PosY = 0; dp.ul12Rgb12Data = 0;
        dp.ul1Clear = 0; dp.ul12ClearRgb = 0; dp.ul1MemWaitRequest = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({dp.ulMemAddress, dp.ul1MemWrite, dp.ul12MemWriteData, dp.ul1Busy,
             dp.ul1Overflow, dp.ul16DropCount} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got addr %0d wr %b data %h busy %b ovf %b drops %0d want all 0",
                     dp.ulMemAddress, dp.ul1MemWrite, dp.ul12MemWriteData, dp.ul1Busy,
                     dp.ul1Overflow, dp.ul16DropCount);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_point();
        obs_q.delete();
        send_point(10, 2, 12'hABC);
        @(negedge clk);
        checks++;
        if (dp.ul1MemWrite !== 1'b0 || dp.ul1Busy !== 1'b1) begin
            errors++;
            $display("FAIL single push cycle: got wr %b busy %b want wr 0 busy 1", dp.ul1MemWrite, dp.ul1Busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dp.ul1MemWrite !== 1'b1 || dp.ulMemAddress !== AW'(650) || dp.ul12MemWriteData !== 12'hABC) begin
            errors++;
            $display("FAIL single write cycle: got wr %b addr %0d data %h want wr 1 addr 650 data abc",
                     dp.ul1MemWrite, dp.ulMemAddress, dp.ul12MemWriteData);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dp.ul1MemWrite !== 1'b0 || dp.ul1Busy !== 1'b0) begin
            errors++;
            $display("FAIL single done: got wr %b busy %b want wr 0 busy 0", dp.ul1MemWrite, dp.ul1Busy);
        end
        exp_q.delete();
        exp_q.push_back(expect_wr(10, 2, 12'hABC));
        compare_queues("single");
    endtask

    task automatic test_out_of_range();
        bit to;
        obs_q.delete();
        exp_q.delete();
        send_point(W, 0, 12'h123);
        send_point(0, H, 12'h456);
        model_drops += 2;
        wait_idle(10, to);
        repeat (3) tick();
        compare_queues("out_of_range");
        check_stats("out_of_range");
    endtask

    task automatic test_backpressure();
        bit to;
        int acc_cycle[$];
        obs_q.delete();
        exp_q.delete();
        dp.ul1MemWaitRequest = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send_point(i, 0, 12'(i * 12'h111));
            exp_q.push_back(expect_wr(i, 0, 12'(i * 12'h111)));
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (dp.ul1MemWrite !== 1'b1 || dp.ulMemAddress !== AW'(1) || dp.ul12MemWriteData !== 12'h111) begin
                errors++;
                $display("FAIL stall hold cycle %0d: got wr %b addr %0d data %h want wr 1 addr 1 data 111",
                         c, dp.ul1MemWrite, dp.ulMemAddress, dp.ul12MemWriteData);
            end
            tick();
        end
        dp.ul1MemWaitRequest = 1'b0;
        for (int c = 0; c < 20 && acc_cycle.size() < 3; c++) begin
            @(negedge clk);
            if (dp.ul1MemWrite && !dp.ul1MemWaitRequest) acc_cycle.push_back(c);
            tick();
        end
        checks++;
        if (acc_cycle.size() != 3 || acc_cycle[2] - acc_cycle[0] != 2) begin
            errors++;
            $display("FAIL backpressure spacing: got %0d acceptances spanning %0d cycles want 3 spanning 2",
                     acc_cycle.size(), acc_cycle.size() == 3 ? acc_cycle[2] - acc_cycle[0] : -1);
        end
        wait_idle(20, to);
        compare_queues("backpressure");
    endtask

    task automatic test_overflow();
        bit to;
        int x, y;
        logic [11:0] rgb;
        obs_q.delete();
        exp_q.delete();
        dp.ul1MemWaitRequest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = $urandom_range(0, W - 1);
            y = $urandom_range(0, H - 1);
            rgb = 12'($urandom);
            send_point(x, y, rgb);
            // A stalled port holds one point in its write register plus a full FIFO of 8.
            if (i < 9) exp_q.push_back(expect_wr(x, y, rgb));
        end
        model_drops += 1;
        model_ovf = 1'b1;
        tick();
        @(negedge clk);
        check_stats("overflow");
        tick();
        dp.ul1MemWaitRequest = 1'b0;
        wait_idle(50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL overflow drain: got busy after 50 cycles want idle");
        end
        compare_queues("overflow");
    endtask

    task automatic test_random_stream();
        bit to;
        int x, y;
        logic [11:0] rgb;
        obs_q.delete();
        exp_q.delete();
        dp.ul1MemWaitRequest = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                x = ($urandom_range(0, 1) == 0) ? $urandom_range(W, 511) : $urandom_range(0, W - 1);
                y = (x >= W) ? $urandom_range(0, 511) : $urandom_range(H, 511);
            end else begin
                x = $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
            end
            rgb = 12'($urandom);
            send_point(x, y, rgb);
            if (x < W && y < H) exp_q.push_back(expect_wr(x, y, rgb));
            else model_drops++;
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle(50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL random_stream drain: got busy after 50 cycles want idle");
        end
        compare_queues("random_stream");
        check_stats("random_stream");
    endtask

    task automatic test_random_backpressure();
        bit to;
        int x, y, n;
        logic [11:0] rgb;
        obs_q.delete();
        exp_q.delete();
        rand_wait = 1'b1;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 9);
            for (int i = 0; i < n; i++) begin
                x = ($urandom_range(0, 5) == 0) ? $urandom_range(W, 511) : $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
                rgb = 12'($urandom);
                send_point(x, y, rgb);
                if (x < W) exp_q.push_back(expect_wr(x, y, rgb));
                else model_drops++;
            end
            wait_idle(200, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL random_backpressure burst %0d drain: got busy want idle", b);
            end
        end
        rand_wait = 1'b0;
        dp.ul1MemWaitRequest = 1'b0;
        tick();
        compare_queues("random_backpressure");
        check_stats("random_backpressure");
    endtask

    task automatic test_clear();
        bit seen_last = 1'b0;
        int bad = 0;
        obs_q.delete();
        dp.ul1MemWaitRequest = 1'b0;
        dp.ul12ClearRgb = 12'h0F0;
        dp.ul1Clear = 1'b1;
        tick();
        dp.ul1Clear = 1'b0;
        dp.ul12ClearRgb = 12'h000;
        for (int i = 0; i < NPIX + 1000; i++) begin
            if (i == 100) begin
                dp.ul1Update = 1'b1; dp.ul9PosX = 9'd5; dp.ul9PosY = 9'd5; dp.ul12Rgb12Data = 12'h123;
            end
            if (i == 105) dp.ul1Update = 1'b0;
            @(negedge clk);
            if (dp.ul1MemWrite && dp.ulMemAddress == AW'(NPIX - 1)) begin
                tick();
                @(negedge clk);
                checks++;
                if (dp.ul1Busy !== 1'b0 || dp.ul1MemWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL clear end: got busy %b wr %b want 0 0", dp.ul1Busy, dp.ul1MemWrite);
                end
                seen_last = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen_last) begin
            errors++;
            $display("FAIL clear timeout: got no write to last address want addr %0d", NPIX - 1);
        end
        repeat (5) tick();
        checks++;
        if (obs_q.size() != NPIX) begin
            errors++;
            $display("FAIL clear write count: got %0d want %0d", obs_q.size(), NPIX);
        end
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i] !== '{addr: AW'(i), data: 12'h0F0}) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear content: got %0d wrong writes want 0", bad);
        end
        model_drops = 0;
        model_ovf = 1'b0;
        check_stats("clear");
    endtask

    task automatic test_reset_mid_clear();
        bit to, hit = 1'b0;
        int x, y;
        logic [11:0] rgb;
        dp.ul12ClearRgb = 12'hF00;
        dp.ul1Clear = 1'b1;
        tick();
        dp.ul1Clear = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dp.ulMemAddress == AW'(1000)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_clear reach: got addr %0d want 1000", dp.ulMemAddress);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dp.ul1MemWrite !== 1'b0 || dp.ul1Busy !== 1'b0 || dp.ulMemAddress !== '0) begin
            errors++;
            $display("FAIL mid_clear async reset: got wr %b busy %b addr %0d want 0 0 0",
                     dp.ul1MemWrite, dp.ul1Busy, dp.ulMemAddress);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (dp.ul1MemWrite !== 1'b0 || dp.ul1Busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear after release: got wr %b busy %b want 0 0", dp.ul1MemWrite, dp.ul1Busy);
        end
        obs_q.delete();
        exp_q.delete();
        model_drops = 0;
        model_ovf = 1'b0;
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
        rgb = 12'($urandom);
        send_point(x, y, rgb);
        exp_q.push_back(expect_wr(x, y, rgb));
        wait_idle(20, to);
        repeat (3) tick();
        compare_queues("post_reset_point");
        check_stats("post_reset_point");
    endtask

    initial begin
        test_reset();
        test_single_point();
        test_out_of_range();
        test_backpressure();
        test_overflow();
        test_random_stream();
        test_random_backpressure();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
